// File: rtl/tdm_demux_2ch_pkg.sv
// Shared frame definitions for the two-channel 1-bit TDM link.
// Used by both the serializer and the deserializer so the frame format matches.
package tdm_pkg;

   localparam int TDM_WIDTH = 8;
   localparam int TDM_WMIN  = 2;
   localparam int TDM_WMAX  = 16;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } tdm_state_e;

   // Slots per frame: A and B interleaved, one bit each per pair of slots.
   function automatic int frame_len(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/tdm_demux_2ch_if.sv
// Serial link bundle between the TDM source and the two-channel deserializer.
// The source drives din/din_valid/frame_sync; the deserializer drives the rest.
interface tdm_demux_2ch_if
   import tdm_pkg::*;
#(
   parameter int WIDTH = TDM_WIDTH
);

   logic             din;
   logic             din_valid;
   logic             frame_sync;
   logic             sel;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic             out_valid;
   logic             sync_err;

   modport master (
      output din, din_valid, frame_sync,
      input  sel, a_out, b_out, out_valid, sync_err
   );

   modport slave (
      input  din, din_valid, frame_sync,
      output sel, a_out, b_out, out_valid, sync_err
   );

endinterface

// File: rtl/tdm_demux_2ch_deint_shift.sv
// Serial-in partial-word shift register for one deinterleaved channel.
// Clear and enable together restart the word with the incoming bit.
module deint_shift #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic         i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_base;
   logic [W-1:0] w_next;

   assign w_base = i_clr ? '0 : r_q;

   generate
      if (W > 1) begin : g_wide
         assign w_next = {w_base[W-2:0], i_d};
      end else begin : g_bit
         assign w_next = i_d;
      end
   endgenerate

   // Shift on enable; a bare clear empties the partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= w_next;
      end else if (i_clr) begin
         r_q <= '0;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/tdm_demux_2ch.sv
// Two-channel TDM deserializer: splits an A/B interleaved bit stream
// back into parallel words with a one-cycle completion strobe.
module tdm_demux_2ch
   import tdm_pkg::*;
#(
   parameter int WIDTH = TDM_WIDTH
) (
   input  logic            clk,
   input  logic            reset,
   tdm_demux_2ch_if.slave  link
);

   localparam int FLEN = frame_len(WIDTH);
   localparam int SW   = $clog2(FLEN);
   localparam logic [SW-1:0] LAST = SW'(FLEN - 1);

   generate
      if (WIDTH < TDM_WMIN || WIDTH > TDM_WMAX) begin : g_bad_width
         $error("tdm_demux_2ch: WIDTH must be in 2..16");
      end
   endgenerate

   tdm_state_e       r_state;
   logic [SW-1:0]    r_slot;
   logic             r_a_msb;
   logic [WIDTH-1:0] r_a_out;
   logic [WIDTH-1:0] r_b_out;
   logic             r_out_valid;
   logic             r_sync_err;

   logic             w_start;
   logic             w_accept;
   logic             w_last;
   logic             w_sel_eff;
   logic             w_en_a;
   logic             w_en_b;
   logic [WIDTH-2:0] w_sh_a;
   logic [WIDTH-2:0] w_sh_b;

   // A sync bit always restarts at slot 0, whatever slot we were in.
   assign w_start   = link.din_valid & link.frame_sync;
   assign w_accept  = link.din_valid &
                      (link.frame_sync | (r_state == ST_RECV));
   assign w_last    = w_accept & ~w_start & (r_slot == LAST);
   assign w_sel_eff = w_start ? 1'b0 : r_slot[0];
   assign w_en_a    = w_accept & ~w_sel_eff;
   assign w_en_b    = w_accept & w_sel_eff;

   // The A register is one bit short; its MSB is kept in r_a_msb.
   deint_shift #(
      .W (WIDTH - 1)
   ) u_shift_a (
      .clk   (clk),
      .rst   (reset),
      .i_en  (w_en_a),
      .i_clr (w_start),
      .i_d   (link.din),
      .o_q   (w_sh_a)
   );

   deint_shift #(
      .W (WIDTH - 1)
   ) u_shift_b (
      .clk   (clk),
      .rst   (reset),
      .i_en  (w_en_b),
      .i_clr (w_start),
      .i_d   (link.din),
      .o_q   (w_sh_b)
   );

   // Frame FSM, slot counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_slot      <= '0;
         r_a_msb     <= 1'b0;
         r_a_out     <= '0;
         r_b_out     <= '0;
         r_out_valid <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_sync_err  <= 1'b0;
         if (w_accept) begin
            if (w_start) begin
               r_state    <= ST_RECV;
               r_slot     <= SW'(1);
               r_a_msb    <= link.din;
               r_sync_err <= (r_state == ST_RECV) && (r_slot != '0);
            end else if (w_last) begin
               r_state     <= ST_IDLE;
               r_slot      <= '0;
               r_a_out     <= {r_a_msb, w_sh_a};
               r_b_out     <= {w_sh_b, link.din};
               r_out_valid <= 1'b1;
            end else begin
               r_slot <= r_slot + SW'(1);
            end
         end
      end
   end

   assign link.sel       = r_slot[0];
   assign link.a_out     = r_a_out;
   assign link.b_out     = r_b_out;
   assign link.out_valid = r_out_valid;
   assign link.sync_err  = r_sync_err;

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Directed bench for the two-channel TDM deserializer (WIDTH=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tdm_demux_2ch;

   logic clk = 1'b0;
   logic reset = 1'b1;

   tdm_demux_2ch_if #(.WIDTH(8)) link ();

   tdm_demux_2ch #(
      .WIDTH (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .link  (link)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int t_start = 0;
   int t_first = 0;
   int n_se = 0;
   int n_both = 0;
   int q_t[$];
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];

   // Edge counter: value k after the k-th rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Capture strobes between edges.
   always @(negedge clk) begin
      if (link.out_valid === 1'b1) begin
         q_t.push_back(cyc);
         q_a.push_back(link.a_out);
         q_b.push_back(link.b_out);
      end
      if (link.sync_err === 1'b1) n_se++;
      if (link.out_valid === 1'b1 && link.sync_err === 1'b1) n_both++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic d, input logic v, input logic fs);
      @(negedge clk);
      link.din        = d;
      link.din_valid  = v;
      link.frame_sync = fs;
      if (v && fs) t_start = cyc + 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic fbit(input logic [7:0] a, input logic [7:0] b,
                                 input int s);
      return s[0] ? b[7 - s/2] : a[7 - s/2];
   endfunction

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
      for (int s = 0; s < 16; s++) drive(fbit(a, b, s), 1'b1, s == 0);
   endtask

   task automatic clear_log();
      q_t.delete();
      q_a.delete();
      q_b.delete();
      n_se = 0;
   endtask

   initial begin
      logic [15:0] vec;
      link.din        = 1'b0;
      link.din_valid  = 1'b0;
      link.frame_sync = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_a", 32'(link.a_out), 32'h0);
      chk("rst_b", 32'(link.b_out), 32'h0);
      chk("rst_ov", 32'(link.out_valid), 32'h0);
      chk("rst_se", 32'(link.sync_err), 32'h0);
      chk("rst_sel", 32'(link.sel), 32'h0);
      reset = 1'b0;
      idle(2);

      // Basic frame from the literal bit stream
      clear_log();
      vec = 16'b1000_1101_0111_0010;
      for (int s = 0; s < 16; s++) drive(vec[15 - s], 1'b1, s == 0);
      idle(3);
      chk("basic_n", 32'(q_a.size()), 32'd1);
      chk("basic_a", 32'(q_a[0]), 32'hA5);
      chk("basic_b", 32'(q_b[0]), 32'h3C);
      chk("basic_lat", 32'(q_t[0] - t_start + 1), 32'd16);
      chk("basic_se", 32'(n_se), 32'd0);

      // Stalls after slot 5 (3 cycles) and slot 12 (1 cycle)
      clear_log();
      for (int s = 0; s < 16; s++) begin
         drive(fbit(8'hA5, 8'h3C, s), 1'b1, s == 0);
         if (s == 0) t_first = t_start;
         chk("stall_sel", 32'(link.sel), 32'(s & 1));
         if (s == 5) begin
            for (int k = 0; k < 3; k++) begin
               drive(1'b1, 1'b0, 1'b1);
               chk("stall_hold0", 32'(link.sel), 32'd0);
            end
         end
         if (s == 12) begin
            drive(1'b0, 1'b0, 1'b0);
            chk("stall_hold1", 32'(link.sel), 32'd1);
         end
      end
      idle(3);
      chk("stall_n", 32'(q_a.size()), 32'd1);
      chk("stall_a", 32'(q_a[0]), 32'hA5);
      chk("stall_b", 32'(q_b[0]), 32'h3C);
      chk("stall_lat", 32'(q_t[0] - t_first + 1), 32'd20);
      chk("stall_se", 32'(n_se), 32'd0);

      // Back-to-back frames
      clear_log();
      send_frame(8'hFF, 8'h00);
      t_first = t_start;
      send_frame(8'h12, 8'h34);
      idle(3);
      chk("b2b_n", 32'(q_a.size()), 32'd2);
      chk("b2b_a0", 32'(q_a[0]), 32'hFF);
      chk("b2b_b0", 32'(q_b[0]), 32'h00);
      chk("b2b_t0", 32'(q_t[0] - t_first + 1), 32'd16);
      chk("b2b_a1", 32'(q_a[1]), 32'h12);
      chk("b2b_b1", 32'(q_b[1]), 32'h34);
      chk("b2b_t1", 32'(q_t[1] - t_first + 1), 32'd32);
      chk("b2b_se", 32'(n_se), 32'd0);

      // Resync at slot 9
      clear_log();
      for (int s = 0; s < 9; s++) drive(fbit(8'h77, 8'h11, s), 1'b1, s == 0);
      send_frame(8'h5A, 8'hC3);
      chk("resync_hold_a", 32'(link.a_out), 32'h12);
      chk("resync_hold_b", 32'(link.b_out), 32'h34);
      idle(3);
      chk("resync_se", 32'(n_se), 32'd1);
      chk("resync_n", 32'(q_a.size()), 32'd1);
      chk("resync_a", 32'(q_a[0]), 32'h5A);
      chk("resync_b", 32'(q_b[0]), 32'hC3);

      // Reset pulsed at slot 7
      clear_log();
      for (int s = 0; s < 7; s++) drive(fbit(8'hAA, 8'h55, s), 1'b1, s == 0);
      @(negedge clk);
      link.din_valid  = 1'b0;
      link.frame_sync = 1'b0;
      reset = 1'b1;
      #1;
      chk("mrst_a", 32'(link.a_out), 32'h0);
      chk("mrst_b", 32'(link.b_out), 32'h0);
      chk("mrst_sel", 32'(link.sel), 32'h0);
      chk("mrst_ov", 32'(link.out_valid), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      send_frame(8'h01, 8'h80);
      idle(3);
      chk("mrst_n", 32'(q_a.size()), 32'd1);
      chk("mrst_fa", 32'(q_a[0]), 32'h01);
      chk("mrst_fb", 32'(q_b[0]), 32'h80);

      // Idle noise, including sync without valid
      clear_log();
      drive(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         drive(1'(i & 1) ^ 1'b1, 1'b1, 1'b0);
         chk("noise_sel", 32'(link.sel), 32'd0);
      end
      idle(3);
      chk("noise_sel_end", 32'(link.sel), 32'd0);
      chk("noise_n", 32'(q_a.size()), 32'd0);
      chk("noise_a", 32'(link.a_out), 32'h01);
      chk("noise_b", 32'(link.b_out), 32'h80);
      chk("noise_se", 32'(n_se), 32'd0);

      chk("excl", 32'(n_both), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
